imem_byte_loader: RTL and testbench

IMEM_BYTE_LOADER -- requirements
Module: imem_byte_loader

---
 rtl/imem_byte_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_byte_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_byte_loader.sv
// imem_byte_loader
// Accepts 32-bit instruction words over a valid/ready stream and writes each
// one into a byte-wide instruction memory as four consecutive byte writes,
// most significant byte first. One start pulse opens a session; the session
// ends on a word flagged in_last or after MAX_WORDS words.
//
// Parameters
//   BASE_ADDR      byte address where every session starts (bits [7:0] used)
//   MAX_WORDS      words per session before the loader stops on its own
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   start          opens a session when idle, ignored otherwise
//   in_valid       in_word holds a word to store
//   in_word        instruction word
//   in_last        in_word is the final word of the session
//   in_ready       loader takes in_word on this cycle's rising edge
//   write_address  byte address to the memory write port ({24'b0, addr8})
//   write_data     byte to the memory write port
//   We             byte write enable
//   busy           session in progress
//   done           one-cycle pulse when the session ends
//   words_loaded   words completely written in the current/last session

module imem_byte_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_word,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] write_address,
  output logic [7:0]  write_data,
  output logic        We,
  output logic        busy,
  output logic        done,
  output logic [7:0]  words_loaded
);

  localparam logic [8:0] MAX_W = MAX_WORDS[8:0];

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  addr8;
  logic [1:0]  byte_idx;
  logic [23:0] word_rest;
  logic        last_reg;
  logic [8:0]  loaded_next;
  logic        session_end;

  // One bit wider than words_loaded so a MAX_WORDS of 256 still compares.
  assign loaded_next = {1'b0, words_loaded} + 9'd1;
  assign session_end = last_reg | (loaded_next >= MAX_W);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the state-decoded handshake/status outputs
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = ACCEPT;
        end
      end
      ACCEPT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        busy = 1'b1;
        if (byte_idx == 2'd3) begin
          next_state = session_end ? DONE : ACCEPT;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath. The accepting edge already launches byte 0 so the write port
  // is busy on the very next cycle; the remaining three bytes are shifted
  // out of word_rest. write_address/write_data keep their last value
  // whenever We drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr8         <= 8'd0;
      byte_idx      <= 2'd0;
      word_rest     <= 24'd0;
      last_reg      <= 1'b0;
      We            <= 1'b0;
      write_address <= 32'd0;
      write_data    <= 8'd0;
      words_loaded  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr8        <= BASE_ADDR[7:0];
            words_loaded <= 8'd0;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            We            <= 1'b1;
            write_address <= {24'd0, addr8};
            write_data    <= in_word[31:24];
            word_rest     <= in_word[23:0];
            last_reg      <= in_last;
            addr8         <= addr8 + 8'd1;
            byte_idx      <= 2'd0;
          end
        end
        WRITE: begin
          if (byte_idx == 2'd3) begin
            We           <= 1'b0;
            words_loaded <= loaded_next[7:0];
          end else begin
            byte_idx      <= byte_idx + 2'd1;
            write_address <= {24'd0, addr8};
            write_data    <= word_rest[23:16];
            word_rest     <= {word_rest[15:0], 8'h00};
            addr8         <= addr8 + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_byte_loader.sv
// tb_imem_byte_loader
// Two loader instances: one with default parameters, one starting at byte
// address 252 with a two-word session limit. Each session is driven through
// one instance; a monitor records every byte write and done pulse, and the
// expected writes, cycles and word counts come from a transaction-level
// model (word j, byte b lands at (base + 4j + b) mod 256 holding the b-th
// most significant byte).

module tb_imem_byte_loader;

  logic              clk;
  logic              rst;
  logic [1:0]        start_s;
  logic [1:0]        valid_s;
  logic [1:0]        last_s;
  logic [1:0][31:0]  word_s;
  wire  [1:0]        ready_s;
  wire  [1:0]        we_s;
  wire  [1:0]        busy_s;
  wire  [1:0]        done_s;
  wire  [1:0][31:0]  wa_s;
  wire  [1:0][7:0]   wd_s;
  wire  [1:0][7:0]   wl_s;

  int base_a [2] = '{0, 252};
  int maxw_a [2] = '{64, 2};

  typedef struct {
    int          idx;
    int          cyc;
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int   idx;
    int   cyc;
    logic busy;
  } dn_t;

  wr_t got_q [$];
  dn_t done_q [$];
  wr_t mon_w;
  dn_t mon_d;

  int          cyc;
  int          n_cmp;
  int          n_err;
  logic [31:0] wbuf [8];
  int          gbuf [8];
  bit          pbuf [8];

  imem_byte_loader u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .in_valid(valid_s[0]),
    .in_word(word_s[0]), .in_last(last_s[0]), .in_ready(ready_s[0]),
    .write_address(wa_s[0]), .write_data(wd_s[0]), .We(we_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .words_loaded(wl_s[0])
  );

  imem_byte_loader #(.BASE_ADDR(32'd252), .MAX_WORDS(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .in_valid(valid_s[1]),
    .in_word(word_s[1]), .in_last(last_s[1]), .in_ready(ready_s[1]),
    .write_address(wa_s[1]), .write_data(wd_s[1]), .We(we_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .words_loaded(wl_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every byte write and done pulse seen mid-cycle
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (we_s[k]) begin
        mon_w.idx  = k;
        mon_w.cyc  = cyc;
        mon_w.addr = wa_s[k];
        mon_w.data = wd_s[k];
        got_q.push_back(mon_w);
      end
      if (done_s[k]) begin
        mon_d.idx  = k;
        mon_d.cyc  = cyc;
        mon_d.busy = busy_s[k];
        done_q.push_back(mon_d);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Runs one session on instance idx with words wbuf[0..nwords-1], gaps
  // gbuf (idle in_valid cycles once the loader is ready again) and pbuf
  // (pulse start during that word's write burst). last_pos < 0 means no
  // word carries in_last.
  task automatic applyStimulus(input int idx, input int nwords, input int last_pos);
    int  lim;
    int  exp_n;
    int  n_offer;
    int  a_prev;
    int  pending;
    int  waited;
    int  w;
    int  b;
    bit  got;
    int  acc_cyc [8];
    logic [31:0] wtmp;
    lim     = (last_pos >= 0) ? last_pos + 1 : nwords;
    exp_n   = (lim < maxw_a[idx]) ? lim : maxw_a[idx];
    n_offer = (nwords > exp_n) ? exp_n + 1 : exp_n;
    foreach (acc_cyc[i]) acc_cyc[i] = 0;
    got_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    start_s[idx] = 1'b1;
    @(posedge clk); #1;
    start_s[idx] = 1'b0;
    a_prev  = cyc - 4;
    pending = 0;
    for (int i = 0; i < n_offer; i++) begin
      if (gbuf[i] > 0) begin
        valid_s[idx] = 1'b0;
        repeat (pending) begin @(posedge clk); #1; end
        pending = 0;
        for (int g = 0; g < gbuf[i]; g++) begin
          @(negedge clk);
          if (i < exp_n) begin
            checkOutput("stall_ready", 32'(ready_s[idx]), 32'd1);
            checkOutput("stall_we", 32'(we_s[idx]), 32'd0);
          end
          @(posedge clk); #1;
        end
      end
      word_s[idx]  = wbuf[i];
      last_s[idx]  = (i == last_pos);
      valid_s[idx] = 1'b1;
      got    = 1'b0;
      waited = 0;
      while (!got && waited < 12) begin
        @(negedge clk);
        if (ready_s[idx]) got = 1'b1;
        @(posedge clk); #1;
        waited++;
      end
      valid_s[idx] = 1'b0;
      last_s[idx]  = 1'b0;
      if (i < exp_n) begin
        checkOutput("accepted", 32'(got), 32'd1);
        if (!got) break;
        checkOutput("accept_cycle", 32'(cyc), 32'(a_prev + 5 + gbuf[i]));
        acc_cyc[i] = cyc;
        a_prev     = cyc;
        pending    = 4;
        if (pbuf[i]) begin
          start_s[idx] = 1'b1;
          @(posedge clk); #1;
          start_s[idx] = 1'b0;
          pending = 3;
        end
      end else begin
        checkOutput("extra_refused", 32'(got), 32'd0);
      end
    end
    repeat (8) @(posedge clk);
    #1;
    checkOutput("byte_count", 32'(got_q.size()), 32'(exp_n * 4));
    for (int j = 0; j < exp_n * 4 && j < got_q.size(); j++) begin
      w    = j / 4;
      b    = j % 4;
      wtmp = wbuf[w];
      checkOutput("wr_inst", 32'(got_q[j].idx), 32'(idx));
      checkOutput("wr_cycle", 32'(got_q[j].cyc), 32'(acc_cyc[w] + b));
      checkOutput("wr_addr", got_q[j].addr, 32'((base_a[idx] + j) % 256));
      checkOutput("wr_data", 32'(got_q[j].data), 32'(wtmp[31 - 8 * b -: 8]));
    end
    checkOutput("done_count", 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) begin
      checkOutput("done_inst", 32'(done_q[0].idx), 32'(idx));
      checkOutput("done_cycle", 32'(done_q[0].cyc), 32'(acc_cyc[exp_n - 1] + 4));
      checkOutput("done_busy", 32'(done_q[0].busy), 32'd0);
    end
    checkOutput("words_loaded", 32'(wl_s[idx]), 32'(exp_n));
    checkOutput("idle_busy", 32'(busy_s[idx]), 32'd0);
    checkOutput("idle_we", 32'(we_s[idx]), 32'd0);
  endtask

  task automatic clearPlan();
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = $urandom;
      gbuf[i] = 0;
      pbuf[i] = 1'b0;
    end
  endtask

  initial begin
    int idx;
    int nw;
    int lp;
    n_cmp   = 0;
    n_err   = 0;
    cyc     = 0;
    rst     = 1'b1;
    start_s = '0;
    valid_s = '0;
    last_s  = '0;
    word_s  = '0;

    // Reset state of both instances
    #3;
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_we", 32'(we_s[k]), 32'd0);
      checkOutput("rst_ready", 32'(ready_s[k]), 32'd0);
      checkOutput("rst_busy", 32'(busy_s[k]), 32'd0);
      checkOutput("rst_done", 32'(done_s[k]), 32'd0);
      checkOutput("rst_addr", wa_s[k], 32'd0);
      checkOutput("rst_data", 32'(wd_s[k]), 32'd0);
      checkOutput("rst_words", 32'(wl_s[k]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single word
    clearPlan();
    wbuf[0] = 32'h8C220004;
    applyStimulus(0, 1, 0);

    // Back-to-back, in_valid held high
    clearPlan();
    applyStimulus(0, 3, 2);

    // Address wrap from 252
    clearPlan();
    applyStimulus(1, 2, 1);

    // Auto-termination at two words, third word left waiting
    clearPlan();
    applyStimulus(1, 3, -1);

    // Long stall in ACCEPT and a start pulse during a write burst
    clearPlan();
    gbuf[0] = 10;
    gbuf[1] = 3;
    pbuf[0] = 1'b1;
    pbuf[1] = 1'b1;
    applyStimulus(0, 2, 1);

    // Reset after byte 1 of a word
    got_q.delete();
    @(posedge clk); #1;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0]  = 1'b0;
    word_s[0]   = $urandom;
    valid_s[0]  = 1'b1;
    @(negedge clk);
    checkOutput("mid_ready", 32'(ready_s[0]), 32'd1);
    @(posedge clk); #1;
    valid_s[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_we", 32'(we_s[0]), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy_s[0]), 32'd0);
    checkOutput("mid_rst_addr", wa_s[0], 32'd0);
    checkOutput("mid_rst_words", 32'(wl_s[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("mid_rst_bytes", 32'(got_q.size()), 32'd2);
    clearPlan();
    applyStimulus(0, 2, 1);

    // Randomized sessions
    for (int s = 0; s < 12; s++) begin
      clearPlan();
      idx = int'($urandom_range(0, 1));
      nw  = int'($urandom_range(1, 5));
      if (idx == 0) lp = int'($urandom_range(0, nw - 1));
      else          lp = int'($urandom_range(0, nw)) - 1;
      for (int i = 0; i < 8; i++) begin
        gbuf[i] = int'($urandom_range(0, 3));
        pbuf[i] = ($urandom_range(0, 3) == 0);
      end
      applyStimulus(idx, nw, lp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
